// File: rtl/fp_lnc_pkg.sv
// Shared widths and constants for the leading-zero counter.
package fp_lnc_pkg;

  localparam int LNC_DW = 32;
  localparam int LNC_ZW = 6;
  localparam int LNC_BW = 8;
  localparam int LNC_NB = LNC_DW / LNC_BW;

  // Result for an all-zero operand.
  localparam logic [LNC_ZW-1:0] LNC_ZERO_CNT = 6'd32;

  // Weight of a byte lane counted from the MSB side: lane LNC_NB-1 is the top byte.
  function automatic logic [LNC_ZW-1:0] lnc_lane_base(input int lane);
    return LNC_ZW'((LNC_NB - 1 - lane) * LNC_BW);
  endfunction

endpackage

// File: rtl/fp_add_sub_lnc_module_if.sv
// Operand / count bundle for the leading-zero counter.
interface fp_add_sub_lnc_module_if;
  import fp_lnc_pkg::*;

  logic [LNC_DW-1:0] A;
  logic [LNC_ZW-1:0] Z;

  // Producer side drives the operand and observes the count.
  modport master (output A, input Z);
  // Counter side consumes the operand and returns the count.
  modport slave  (input A, output Z);

endinterface

// File: rtl/fp_lnc_byte.sv
// Leading-zero count of one byte, plus an all-zero flag for the lane selector.
module fp_lnc_byte
  import fp_lnc_pkg::*;
(
  input  logic [LNC_BW-1:0] d,
  output logic [3:0]        cnt,
  output logic              all_zero
);

  // Scan upward so the highest set bit is the last (winning) assignment.
  always_comb begin
    cnt      = 4'd8;
    all_zero = 1'b1;
    for (int i = 0; i < LNC_BW; i++) begin
      if (d[i]) begin
        cnt      = 4'(LNC_BW - 1 - i);
        all_zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fp_add_sub_lnc_module.sv
// Registered 32-bit leading-zero counter built from four byte-wide counters.
module fp_add_sub_lnc_module
  import fp_lnc_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  fp_add_sub_lnc_module_if.slave   bus
);

  logic [3:0]        lane_cnt [LNC_NB];
  logic [LNC_NB-1:0] lane_zero;
  logic [LNC_ZW-1:0] cnt_next;

  for (genvar g = 0; g < LNC_NB; g++) begin : g_lane
    fp_lnc_byte u_byte (
      .d        (bus.A[g*LNC_BW +: LNC_BW]),
      .cnt      (lane_cnt[g]),
      .all_zero (lane_zero[g])
    );
  end

  // Pick the most significant non-zero lane; lower lanes are overwritten by higher ones.
  always_comb begin
    cnt_next = LNC_ZERO_CNT;
    for (int b = 0; b < LNC_NB; b++) begin
      if (!lane_zero[b]) begin
        cnt_next = lnc_lane_base(b) + LNC_ZW'(lane_cnt[b]);
      end
    end
  end

  // Single output register; reset clears it immediately and drops any pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.Z <= '0;
    end else begin
      bus.Z <= cnt_next;
    end
  end

endmodule

// File: tb/tb_fp_add_sub_lnc_module.sv
// Directed and random checks for the registered leading-zero counter.
module tb_fp_add_sub_lnc_module;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fails  = 0;

  fp_add_sub_lnc_module_if bus ();

  fp_add_sub_lnc_module dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Bit-by-bit reference, deliberately not byte-structured.
  function automatic int ref_lzc(input logic [31:0] a);
    for (int i = 31; i >= 0; i--) begin
      if (a[i]) return 31 - i;
    end
    return 32;
  endfunction

  // Drive A away from the edge, then sample one cycle later.
  task automatic apply(input string tag, input logic [31:0] a, input int exp);
    @(negedge clk);
    bus.A = a;
    @(posedge clk);
    #1;
    check_val(tag, 32'(bus.Z), 32'(exp));
  endtask

  logic [31:0] dir_a   [14];
  int          dir_exp [14];

  initial begin
    logic [31:0] a;
    int          k;
    int          r;

    dir_a   = '{32'h20030000, 32'h01F00010, 32'h00FFF010, 32'h00011000, 32'h0000000E,
                32'h00000003, 32'h80000000, 32'h00000001, 32'h00000000, 32'hFFFFFFFF,
                32'h00800000, 32'h00008000, 32'h00000080, 32'h00000100};
    dir_exp = '{2, 7, 8, 15, 28, 30, 0, 31, 32, 0, 8, 16, 24, 23};

    bus.A = 32'hFFFF_FFFF;
    #2 rst = 1'b1;
    #1 check_val("reset_async", 32'(bus.Z), 32'd0);
    repeat (2) @(posedge clk);
    #1 check_val("reset_held", 32'(bus.Z), 32'd0);

    // First edge after release must already carry the count.
    @(negedge clk);
    rst   = 1'b0;
    bus.A = 32'h0000_0400;
    @(posedge clk);
    #1 check_val("first_after_reset", 32'(bus.Z), 32'd21);

    for (int i = 31; i >= 0; i--) begin
      apply("sweep", 32'h1 << i, 31 - i);
    end

    for (int i = 0; i < 14; i++) begin
      apply("directed", dir_a[i], dir_exp[i]);
    end

    // Output must not follow A between edges.
    apply("hold_pre", 32'h0001_0000, 15);
    @(negedge clk);
    bus.A = 32'h8000_0000;
    #1 check_val("no_comb_path", 32'(bus.Z), 32'd15);
    @(posedge clk);
    #1 check_val("no_comb_next", 32'(bus.Z), 32'd0);

    apply("rst_pre", 32'h0000_0001, 31);
    @(negedge clk);
    rst = 1'b1;
    #1 check_val("rst_mid_immediate", 32'(bus.Z), 32'd0);
    bus.A = 32'h0000_0010;
    @(posedge clk);
    #1 check_val("rst_mid_held", 32'(bus.Z), 32'd0);
    @(negedge clk);
    bus.A = 32'h0000_0001;
    rst   = 1'b0;
    #1 check_val("rst_release_wait", 32'(bus.Z), 32'd0);
    @(posedge clk);
    #1 check_val("rst_release_count", 32'(bus.Z), 32'd31);

    for (int i = 0; i < 10000; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        a = 32'h0;
      end else if (r <= 3) begin
        k = $urandom_range(0, 31);
        a = (32'h1 << k) | ($urandom & ((32'h1 << k) - 32'h1));
      end else begin
        a = $urandom;
      end
      apply("random", a, ref_lzc(a));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/fp_add_sub_lnc_module.md
FP_ADD_SUB_LNC_MODULE -- requirements
Module: fp_add_sub_lnc_module

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits and count width at 6 bits.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, with ports named as follows.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 A  input  32  operand whose leading zeros are counted; bit 31 is the MSB.
REQ-006 Z  output  6  registered leading-zero count of A, unsigned, range 0..32.

Function
REQ-007 Z SHALL be the number of consecutive zero bits in A, counted from bit 31 downward, up to the first 1 bit.
- MSB set -> 0.
- Only bit 0 set -> 31.
REQ-008 A == 0 SHALL produce Z == 32 (6'b100000); no separate zero flag exists.
REQ-009 Bits below the leading 1 SHALL NOT affect Z.
- Example: 0x20030000 and 0x20000000 both give 2.
REQ-010 Latency SHALL be exactly one cycle: Z after rising edge N reflects A sampled at edge N.
REQ-011 Z SHALL be stable between rising edges and SHALL NOT change combinationally with A.
REQ-012 A new A value SHALL be accepted every cycle, with no handshake or stall.
REQ-013 Each cycle's result SHALL depend only on that cycle's A, with no history.
REQ-014 A containing X/Z bits SHALL NOT be supported; the resulting Z is unspecified.

Reset
REQ-015 Asserting rst SHALL force Z to 6'd0 immediately, without waiting for a clock edge.
REQ-016 While rst is high, Z SHALL hold 0 regardless of A or clk.
REQ-017 On the first rising edge after rst deasserts, Z SHALL take the count of the A present at that edge.
REQ-018 Reset asserted mid-stream SHALL discard the pending result with no other side effect.

Structure
REQ-019 A shared package fp_lnc_pkg SHALL hold:
- LNC_DW = 32 and LNC_ZW = 6.
- The all-zero result constant LNC_ZERO_CNT = 32.
REQ-020 The count SHALL be computed hierarchically with four instances of one sub-module, fp_lnc_byte:
- Each instance takes 8 bits and outputs a 4-bit zero-count plus an all-zero flag.
REQ-021 The top level SHALL select the first byte (from the MSB side) that is not all-zero and form Z = 8*byte_index + byte_count.
- If all four bytes are zero, Z = 32.
REQ-022 Only the output register stage SHALL be clocked; the count logic SHALL be purely combinational.

Verification
REQ-023 Single-bit sweep: A = 1<<k for k = 31..0 applied on consecutive cycles -> Z = 31-k, each one cycle after its A.
REQ-024 Trailing-garbage cases:
- 0x20030000 -> 2.
- 0x01F00010 -> 7.
- 0x00FFF010 -> 8.
- 0x00011000 -> 15.
- 0x0000000E -> 28.
- 0x00000003 -> 30.
REQ-025 Boundary values:
- 0x80000000 -> 0.
- 0x00000001 -> 31.
- 0x00000000 -> 32.
- 0xFFFFFFFF -> 0.
REQ-026 Byte-boundary values:
- 0x00800000 -> 8.
- 0x00008000 -> 16.
- 0x00000080 -> 24.
- 0x00000100 -> 23.
REQ-027 Asynchronous reset with A = 0x00000001 held:
- Raise rst between edges -> Z = 0 immediately, before the next edge.
- Release rst -> Z = 31 after the next rising edge.
REQ-028 Random check: 10,000 random A values, including ~10% zero and values with a forced single leading 1 -> Z matches a reference count delayed by one cycle, with no mismatches.
